// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit for the execute stage: shift-add multiply
// and restoring divide on operand magnitudes, one iteration per clock, with stall and tag.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAGW-1:0]  tag_in,
  output logic             busy,
  output logic             stall,
  output logic             result_rdy,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [TAGW-1:0]  tag_out
);

  localparam int CNTW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0]  CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNTW-1:0]    cnt_r;
  logic [WIDTH-1:0]   a_mag_r;
  logic [WIDTH-1:0]   b_mag_r;
  logic               sign_r;
  logic [TAGW-1:0]    tag_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   result_r;
  logic               exception_r;
  logic [TAGW-1:0]    tag_out_r;

  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH-1:0]   div_part_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [WIDTH-1:0]   mul_res_s;
  logic               mul_exc_s;
  logic [WIDTH-1:0]   div_res_s;
  logic               div_exc_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = ~v + ONE_W;
  endfunction

  // Two's-complement magnitude; INT_MIN maps to 2^(WIDTH-1) as an unsigned value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      magnitude = negate(v);
    end else begin
      magnitude = v;
    end
  endfunction

  // One multiply step ({hi,lo} with multiplier in lo) and one restoring divide step ({rem,quo}).
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
               + (acc_r[0] ? {1'b0, a_mag_r} : {(WIDTH+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    // remainder stays below the divisor, so its top bit is always clear and can be dropped
    div_part_s = acc_r[2*WIDTH-2:WIDTH-1];
    div_diff_s = {1'b0, div_part_s} - {1'b0, b_mag_r};
    if (!div_diff_s[WIDTH]) begin
      div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {div_part_s, acc_r[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix and overflow detection applied on the final iteration.
  always_comb begin
    if (sign_r) begin
      mul_res_s = negate(mul_next_s[WIDTH-1:0]);
      mul_exc_s = (mul_next_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}})
                | (mul_next_s[WIDTH-1] & (mul_next_s[WIDTH-2:0] != {(WIDTH-1){1'b0}}));
      div_res_s = negate(div_next_s[WIDTH-1:0]);
      div_exc_s = 1'b0;
    end else begin
      mul_res_s = mul_next_s[WIDTH-1:0];
      mul_exc_s = (mul_next_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b0}});
      div_res_s = div_next_s[WIDTH-1:0];
      div_exc_s = div_next_s[WIDTH-1];
    end
  end

  // Sequencer FSM with operand capture, iteration and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNTW{1'b0}};
      a_mag_r     <= {WIDTH{1'b0}};
      b_mag_r     <= {WIDTH{1'b0}};
      sign_r      <= 1'b0;
      tag_r       <= {TAGW{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      result_r    <= {WIDTH{1'b0}};
      exception_r <= 1'b0;
      tag_out_r   <= {TAGW{1'b0}};
    end else if (flush) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNTW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          cnt_r   <= {CNTW{1'b0}};
          a_mag_r <= magnitude(operand_a);
          b_mag_r <= magnitude(operand_b);
          sign_r  <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
          tag_r   <= tag_in;
          if (start_mul) begin
            acc_r   <= {{WIDTH{1'b0}}, magnitude(operand_b)};
            state_r <= S_MUL;
          end else if (start_div) begin
            acc_r <= {{WIDTH{1'b0}}, magnitude(operand_a)};
            if (operand_b == {WIDTH{1'b0}}) begin
              result_r    <= {WIDTH{1'b0}};
              exception_r <= 1'b1;
              tag_out_r   <= tag_in;
              state_r     <= S_DONE;
            end else begin
              state_r <= S_DIV;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_MUL: begin
          acc_r <= mul_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            result_r    <= mul_res_s;
            exception_r <= mul_exc_s;
            tag_out_r   <= tag_r;
            state_r     <= S_DONE;
          end
        end
        S_DIV: begin
          acc_r <= div_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            result_r    <= div_res_s;
            exception_r <= div_exc_s;
            tag_out_r   <= tag_r;
            state_r     <= S_DONE;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_r != S_IDLE);
  assign result_rdy = (state_r == S_DONE);
  assign stall      = ((state_r == S_IDLE) & (start_mul | start_div) & ~flush)
                    | (state_r == S_MUL) | (state_r == S_DIV);
  assign result     = result_r;
  assign exception  = exception_r;
  assign tag_out    = tag_out_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer with hand-computed expectations.
module tb_muldiv_sequencer;

  logic        clock;
  logic        reset;
  logic        start_mul;
  logic        start_div;
  logic        flush;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  tag_in;
  logic        busy;
  logic        stall;
  logic        result_rdy;
  logic [31:0] result;
  logic        exception;
  logic [4:0]  tag_out;

  int check_cnt = 0;
  int err_cnt   = 0;

  muldiv_sequencer #(.WIDTH(32), .TAGW(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_mul  (start_mul),
    .start_div  (start_div),
    .flush      (flush),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .tag_in     (tag_in),
    .busy       (busy),
    .stall      (stall),
    .result_rdy (result_rdy),
    .result     (result),
    .exception  (exception),
    .tag_out    (tag_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation from IDLE (called at posedge+1) and follow it through DONE.
  task automatic do_op(input logic is_mul, input logic is_div,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                       input int exp_lat, input logic [31:0] exp_res, input logic exp_exc,
                       input logic poke_done, input string name);
    int   lat;
    logic stall_ok;
    operand_a = a;
    operand_b = b;
    tag_in    = tag;
    start_mul = is_mul;
    start_div = is_div;
    #1;
    check_val({name, "_stall_start"}, {31'd0, stall}, 32'd1);
    next_cycle();
    start_mul = 1'b0;
    start_div = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    tag_in    = 5'($urandom);
    lat       = 0;
    stall_ok  = 1'b1;
    while (!result_rdy && lat < 200) begin
      if (!stall || !busy) stall_ok = 1'b0;
      next_cycle();
      lat++;
    end
    check_val({name, "_latency"}, lat, exp_lat);
    check_val({name, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
    check_val({name, "_result"}, result, exp_res);
    check_val({name, "_exception"}, {31'd0, exception}, {31'd0, exp_exc});
    check_val({name, "_tag"}, {27'd0, tag_out}, {27'd0, tag});
    check_val({name, "_stall_done"}, {31'd0, stall}, 32'd0);
    check_val({name, "_busy_done"}, {31'd0, busy}, 32'd1);
    if (poke_done) begin
      start_mul = 1'b1;
      operand_a = 32'd2;
      operand_b = 32'd2;
    end
    next_cycle();
    start_mul = 1'b0;
    check_val({name, "_rdy_pulse"}, {31'd0, result_rdy}, 32'd0);
    check_val({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic rdy_seen;
    reset     = 1'b1;
    start_mul = 1'b0;
    start_div = 1'b0;
    flush     = 1'b0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    tag_in    = 5'd0;
    #1 reset = 1'b0;
    repeat (2) next_cycle();
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_rdy", {31'd0, result_rdy}, 32'd0);
    check_val("rst_result", result, 32'd0);
    check_val("rst_exc", {31'd0, exception}, 32'd0);
    check_val("rst_tag", {27'd0, tag_out}, 32'd0);
    reset = 1'b1;
    next_cycle();

    do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32, 32'hFFFF_FFEB, 1'b0, 1'b0, "mul_7_m3");
    do_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd1, 32, 32'h0000_0000, 1'b1, 1'b0, "mul_ovf");
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32, 32'h8000_0000, 1'b1, 1'b1, "mul_min_m1");
    do_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 5'd12, 32, 32'hFFFF_FFF2, 1'b0, 1'b0, "div_m100_7");

    // flush a divide at iteration 10: nothing completes, previous result survives
    operand_a = 32'd1000;
    operand_b = 32'd3;
    tag_in    = 5'd4;
    start_div = 1'b1;
    next_cycle();
    start_div = 1'b0;
    repeat (10) next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    check_val("flush_busy", {31'd0, busy}, 32'd0);
    check_val("flush_stall", {31'd0, stall}, 32'd0);
    check_val("flush_rdy", {31'd0, result_rdy}, 32'd0);
    check_val("flush_result", result, 32'hFFFF_FFF2);
    check_val("flush_exc", {31'd0, exception}, 32'd0);
    check_val("flush_tag", {27'd0, tag_out}, 32'd12);
    rdy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_rdy) rdy_seen = 1'b1;
      next_cycle();
    end
    check_val("flush_no_rdy", {31'd0, rdy_seen}, 32'd0);
    do_op(1'b1, 1'b0, 32'd6, 32'd7, 5'd3, 32, 32'd42, 1'b0, 1'b0, "mul_6_7");

    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32, 32'h8000_0000, 1'b1, 1'b0, "div_min_m1");
    do_op(1'b0, 1'b1, 32'd1000, 32'hFFFF_FFF9, 5'd6, 32, 32'hFFFF_FF72, 1'b0, 1'b0, "div_1000_m7");
    do_op(1'b0, 1'b1, 32'd55, 32'd0, 5'd7, 0, 32'd0, 1'b1, 1'b0, "div_by_zero");
    do_op(1'b1, 1'b1, 32'd10, 32'd3, 5'd8, 32, 32'd30, 1'b0, 1'b0, "both_starts");
    repeat (5) next_cycle();
    check_val("hold_result", result, 32'd30);
    check_val("hold_tag", {27'd0, tag_out}, 32'd8);

    // asynchronous reset in the middle of a multiply
    operand_a = 32'd123;
    operand_b = 32'd456;
    tag_in    = 5'd17;
    start_mul = 1'b1;
    next_cycle();
    start_mul = 1'b0;
    repeat (20) next_cycle();
    #2 reset = 1'b0;
    #1;
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    check_val("arst_stall", {31'd0, stall}, 32'd0);
    check_val("arst_rdy", {31'd0, result_rdy}, 32'd0);
    check_val("arst_result", result, 32'd0);
    check_val("arst_tag", {27'd0, tag_out}, 32'd0);
    next_cycle();
    reset = 1'b1;
    next_cycle();

    // start together with flush is dropped
    operand_a = 32'd5;
    operand_b = 32'd5;
    start_mul = 1'b1;
    flush     = 1'b1;
    #1;
    check_val("flush_start_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    start_mul = 1'b0;
    flush     = 1'b0;
    check_val("flush_start_busy", {31'd0, busy}, 32'd0);
    do_op(1'b1, 1'b0, 32'hFFFF_FFFA, 32'd7, 5'd31, 32, 32'hFFFF_FFD6, 1'b0, 1'b0, "mul_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative signed multiply/divide engine that owns the execute-stage mul/div resource.
- Sequences 32-bit shift-add multiply and restoring divide over WIDTH cycles.
- Generates the pipeline stall and tags the result with its destination register.
- Sits beside the ALU in execute; the processor drives stall_fetch/decode/execute from its stall output.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH
TAGW, 5, destination-register tag width

Ports:
clock  input  1  master clock, rising-edge
reset  input  1  asynchronous, active-low reset
start_mul  input  1  request signed multiply; sampled at rising edge
start_div  input  1  request signed divide; sampled at rising edge
flush  input  1  abort current or pending operation (control-flow flush)
operand_a  input  WIDTH  multiplicand / dividend, sampled with start
operand_b  input  WIDTH  multiplier / divisor, sampled with start
tag_in  input  TAGW  destination register, sampled with start
busy  output  1  high in MUL, DIV and DONE states
stall  output  1  pipeline hold request (combinational)
result_rdy  output  1  one-cycle pulse, result valid
result  output  WIDTH  low WIDTH bits of product, or quotient
exception  output  1  overflow or divide-by-zero for the current result
tag_out  output  TAGW  tag captured with the operation

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy, result_rdy, exception = 0; result = 0; tag_out = 0; counter = 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start_mul at edge k: latch |a|, |b|, sign = a[W-1]^b[W-1], tag_in; counter = 0; go to MUL.
  - start_div at edge k: same latching; go to DIV.
  - Both starts high: start_mul wins; start_div ignored.
- MUL/DIV: one iteration per edge, at edges k+1..k+WIDTH; counter increments each iteration.
  - At edge k+WIDTH: final iteration done; sign fix applied; result, exception registered; state goes to DONE.
- DONE: result_rdy = 1 for exactly this one cycle; next edge goes to IDLE.
  - Latency: result_rdy is high in the cycle following edge k+WIDTH.
  - A start in DONE is ignored; no back-to-back overlap.
- stall = (IDLE & (start_mul | start_div) & !flush) | MUL | DIV.
  - stall is low in DONE, so the pipeline advances and captures result in that cycle.
- Multiply:
  - 2W-bit unsigned shift-add on magnitudes, then negate if sign.
  - result = low W bits.
  - exception = 1 when the signed 2W-bit product is not representable in W bits. Example: INT_MIN*-1 gives result 0x80000000, exception 1.
- Divide:
  - Restoring division on magnitudes; quotient truncates toward zero; quotient negated if sign; remainder discarded.
  - INT_MIN / -1: result 0x80000000, exception 1.
  - Divisor 0 detected at start: next edge goes straight to DONE with result 0, exception 1. result_rdy arrives one cycle after start; stall is high only in the start cycle.
- Hold: result, exception and tag_out hold their last values until the next completion.
- Invariant: busy=0 implies result_rdy=0.
- Starts while in MUL/DIV/DONE are ignored. No queueing; the processor guarantees this via stall.
- flush: at the next edge, any state goes to IDLE. No result_rdy; result/exception/tag_out keep their previous values.
  - flush and start in the same cycle: flush wins; start dropped; stall low that cycle.
  - flush in DONE: that cycle's result_rdy still shows, because it is combinational from state; the pipeline discards it.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. After reset release, the first start proceeds normally.

Test Plan:
- a=7, b=-3, start_mul pulse -> stall high 32 cycles; result_rdy single pulse in the cycle after edge k+32; result 0xFFFFFFEB; exception 0; tag_out = tag_in (5'd9).
- a=0x00010000, b=0x00010000, multiply -> result 0x00000000, exception 1; separately INT_MIN*-1 -> 0x80000000, exception 1.
- a=-100, b=7, divide -> result 0xFFFFFFF2 (-14); exception 0. Then a=0x80000000, b=-1 -> result 0x80000000, exception 1.
- a=55, b=0, divide -> result_rdy one cycle after start; result 0; exception 1; stall high only in the start cycle.
- start_div, flush at iteration 10 -> busy 0 and stall 0 after the next edge; no result_rdy; result unchanged. Immediate new start_mul (6*7) -> 42 after 32 cycles.
- reset driven low mid-multiply (iteration 20), asynchronously without a clock edge -> busy, stall, result_rdy, result, tag_out all 0 immediately. start_mul asserted with flush in the same cycle -> ignored, state stays IDLE.
